tdoa_capture_ctrl: RTL

Measurement sequencer for the detection timer path. It arms a capture window and starts the shared timestamp counter at the first microphone detection. It latches one timestamp per channel, closes the window on completion or timeout, and streams the per-channel results to the downstream consumer over a valid/ready handshake. It sits between the per-microphone `detect` comparators and the readout/host interface.

---
 rtl/tdoa_pkg.sv | 19 +
 rtl/timestamp_counter.sv | 20 ++
 rtl/tdoa_capture_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/tdoa_pkg.sv
// Shared definitions for the TDOA capture path: controller state encoding,
// the missing-timestamp marker and the channel-index width helper.
package tdoa_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        READOUT = 2'd3
    } state_t;

    // All ones; sliced to the timestamp width by the user.
    localparam logic [63:0] TS_MISSING = '1;

    function automatic int ch_idx_w(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

endpackage

// File: rtl/timestamp_counter.sv
// Shared timestamp counter: synchronous clear, count enable, saturates at all ones.
module timestamp_counter #(
    parameter int TS_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            en,
    output logic [TS_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + TS_W'(1);
        end
    end

endmodule

// File: rtl/tdoa_capture_ctrl.sv
// Measurement sequencer: arms a capture window, timestamps the first rise of each
// detect channel relative to the earliest rise, then streams results over valid/ready.
module tdoa_capture_ctrl
    import tdoa_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int TS_W   = 16,
    parameter int WINDOW = 1000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       arm,
    input  logic [N_CH-1:0]            detect,
    output logic                       busy,
    output logic                       timeout,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ch_idx_w(N_CH)-1:0]  out_ch,
    output logic [TS_W-1:0]            out_ts,
    output logic                       done
);

    localparam int              CH_W    = ch_idx_w(N_CH);
    localparam logic [TS_W-1:0] TS_MISS = TS_MISSING[TS_W-1:0];
    localparam logic [TS_W-1:0] WIN_TS  = TS_W'(WINDOW);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

    state_t            state_reg;
    logic [N_CH-1:0]   detect_q;
    logic [N_CH-1:0]   mask_reg;
    logic [N_CH-1:0]   rise;
    logic [N_CH-1:0]   capt_now;
    logic [N_CH-1:0]   mask_cap;
    logic [N_CH-1:0]   fill_now;
    logic [TS_W-1:0]   ts_reg  [N_CH];
    logic [TS_W-1:0]   ts_next [N_CH];
    logic [TS_W-1:0]   count;
    logic              cnt_clr;
    logic              cnt_en;
    logic              in_window;
    logic              all_cap;
    logic              window_end;
    logic [CH_W-1:0]   ch_inc;

    // Mask is cleared on arm, so in ARMED this reduces to plain rise.
    assign rise       = detect & ~detect_q;
    assign in_window  = (state_reg == ARMED) || (state_reg == CAPTURE);
    assign capt_now   = in_window ? (rise & ~mask_reg) : '0;
    assign mask_cap   = mask_reg | capt_now;
    assign all_cap    = &mask_cap;
    assign window_end = (state_reg == CAPTURE) && (count == WIN_TS) && !all_cap;
    assign fill_now   = window_end ? ~mask_cap : '0;
    assign cnt_clr    = (state_reg == IDLE) && arm;
    assign cnt_en     = ((state_reg == ARMED) && (|rise)) || (state_reg == CAPTURE);
    assign ch_inc     = out_ch + CH_W'(1);

    timestamp_counter #(
        .TS_W (TS_W)
    ) u_counter (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            detect_q <= '0;
        end else begin
            detect_q <= detect;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            assign ts_next[gi] = capt_now[gi] ? count :
                                 fill_now[gi] ? TS_MISS : ts_reg[gi];

            always_ff @(posedge clk) begin
                if (rst) begin
                    ts_reg[gi] <= '0;
                end else begin
                    ts_reg[gi] <= ts_next[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            mask_reg  <= '0;
            busy      <= 1'b0;
            timeout   <= 1'b0;
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_ts    <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (arm) begin
                        state_reg <= ARMED;
                        mask_reg  <= '0;
                        timeout   <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                ARMED: begin
                    if (|rise) begin
                        mask_reg  <= mask_cap;
                        state_reg <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    mask_reg <= mask_cap;
                    if (all_cap || window_end) begin
                        state_reg <= READOUT;
                        out_valid <= 1'b1;
                        out_ch    <= '0;
                        out_ts    <= ts_next[0];
                        timeout   <= window_end;
                    end
                end
                READOUT: begin
                    // The done cycle is spent here so an arm coincident with done is ignored.
                    if (done) begin
                        state_reg <= IDLE;
                    end else if (out_valid && out_ready) begin
                        if (out_ch == LAST_CH) begin
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            out_ch <= ch_inc;
                            out_ts <= ts_reg[ch_inc];
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
